// File: rtl/queue_pkg.sv
// Shared definitions for the queue enemy sprite: motion state encoding,
// sprite/screen geometry used by both the motion and colour stages, and the
// walk-frame codes carried on animate_state.
package queue_pkg;

  // Motion controller states (2-bit encoding)
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WALK_LEFT  = 2'd1;
  localparam logic [1:0] ST_WALK_RIGHT = 2'd2;
  localparam logic [1:0] ST_DEAD       = 2'd3;

  // Sprite and screen geometry
  localparam int QUEUE_WIDTH  = 44;
  localparam int QUEUE_HEIGHT = 50;
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;

  // Walk frame select codes
  localparam logic QUEUE_LEFT  = 1'b0;
  localparam logic QUEUE_RIGHT = 1'b1;

endpackage

// File: rtl/queue_frame_counter.sv
// Modulo-N tick counter: counts enabled cycles 0..N-1 and pulses wrap on the
// enabled cycle that holds N-1 (the counter returns to 0 on that same edge).
// Latency: wrap is combinational from the current count; count updates next edge.
// Ports: clk, rst_n (async active-low), clr (sync clear, wins over en), en, wrap.
module queue_frame_counter
  import queue_pkg::*;
#(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/queue_motion.sv
// Queue enemy motion: patrols between X_MIN/X_MAX at GROUND_Y, toggles its walk
// frame every ANIM_FRAMES ticks, freezes DEAD_FRAMES ticks when stomped, respawns.
// Latency: all outputs registered, updated on the edge sampling frame_tick/stomp.
// Ports: clk, rst_n, frame_tick, enable, stomp in; posx, posy, animate_state, alive out.
module queue_motion
  import queue_pkg::*;
#(
  parameter int X_MIN       = 0,
  parameter int X_MAX       = SCREEN_W - QUEUE_WIDTH,
  parameter int START_X     = 300,
  parameter int GROUND_Y    = 380,
  parameter int SPEED       = 1,
  parameter int ANIM_FRAMES = 8,
  parameter int DEAD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       stomp,
  output logic [9:0] posx,
  output logic [8:0] posy,
  output logic       animate_state,
  output logic       alive
);

  // Bound checks are done on 11 bits so neither posx - SPEED nor
  // posx + SPEED can wrap before being compared.
  localparam logic [10:0] LEFT_LIMIT  = 11'(X_MIN + SPEED);
  localparam logic [10:0] RIGHT_LIMIT = 11'(X_MAX);
  localparam logic [10:0] SPEED_11    = 11'(SPEED);
  localparam logic [9:0]  SPEED_10    = 10'(SPEED);
  localparam logic [9:0]  X_MIN_10    = 10'(X_MIN);
  localparam logic [9:0]  X_MAX_10    = 10'(X_MAX);
  localparam logic [9:0]  START_X_10  = 10'(START_X);
  localparam logic [8:0]  GROUND_Y_9  = 9'(GROUND_Y);

  logic [1:0] state_q, state_d;
  logic [9:0] posx_q, posx_d;
  logic [8:0] posy_q, posy_d;
  logic       anim_q, anim_d;
  logic       alive_q, alive_d;

  logic       walking;
  logic       stomp_hit;
  logic       move;
  logic       anim_wrap;
  logic       dead_tick;
  logic       dead_wrap;
  logic [10:0] posx_ext;

  assign walking   = (state_q == ST_WALK_LEFT) || (state_q == ST_WALK_RIGHT);
  // A stomp pre-empts any tick arriving in the same cycle.
  assign stomp_hit = walking && stomp;
  assign move      = walking && frame_tick && enable && !stomp;
  // The death timer runs even while the game is paused.
  assign dead_tick = (state_q == ST_DEAD) && frame_tick;
  assign posx_ext  = {1'b0, posx_q};

  // Walk-frame timer: restarts from zero on respawn so a fresh sprite
  // always begins on a full animation period.
  queue_frame_counter #(.N(ANIM_FRAMES)) u_anim_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (dead_wrap),
    .en    (move),
    .wrap  (anim_wrap)
  );

  // Death timer: zeroed by the stomp, expires on its DEAD_FRAMES-th tick.
  queue_frame_counter #(.N(DEAD_FRAMES)) u_dead_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stomp_hit),
    .en    (dead_tick),
    .wrap  (dead_wrap)
  );

  always_comb begin
    state_d = state_q;
    posx_d  = posx_q;
    posy_d  = posy_q;
    anim_d  = anim_q;
    alive_d = alive_q;
    case (state_q)
      ST_IDLE: begin
        // Start tick only arms the sprite; the first move is one tick later.
        if (frame_tick && enable) begin
          state_d = ST_WALK_LEFT;
          alive_d = 1'b1;
        end
      end
      ST_WALK_LEFT, ST_WALK_RIGHT: begin
        if (stomp_hit) begin
          state_d = ST_DEAD;
          alive_d = 1'b0;
        end else if (move) begin
          if (anim_wrap) begin
            anim_d = ~anim_q;
          end
          if (state_q == ST_WALK_LEFT) begin
            if (posx_ext < LEFT_LIMIT) begin
              posx_d  = X_MIN_10;
              state_d = ST_WALK_RIGHT;
            end else begin
              posx_d = posx_q - SPEED_10;
            end
          end else begin
            if ((posx_ext + SPEED_11) > RIGHT_LIMIT) begin
              posx_d  = X_MAX_10;
              state_d = ST_WALK_LEFT;
            end else begin
              posx_d = posx_q + SPEED_10;
            end
          end
        end
      end
      default: begin
        if (dead_wrap) begin
          posx_d  = START_X_10;
          anim_d  = QUEUE_LEFT;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      posx_q  <= START_X_10;
      posy_q  <= GROUND_Y_9;
      anim_q  <= QUEUE_LEFT;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      posx_q  <= posx_d;
      posy_q  <= posy_d;
      anim_q  <= anim_d;
      alive_q <= alive_d;
    end
  end

  assign posx          = posx_q;
  assign posy          = posy_q;
  assign animate_state = anim_q;
  assign alive         = alive_q;

endmodule

// File: tb/tb_queue_motion.sv
// Bench for queue_motion: two instances (default parameters and a small-bound
// variant with X_MIN=0, START_X=2, SPEED=3) share one stimulus stream and are
// compared against a per-tick behavioural model of the sprite.
module tb_queue_motion;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       enable = 1'b0;
  logic       stomp = 1'b0;
  logic [9:0] posx0, posx1;
  logic [8:0] posy0, posy1;
  logic       anim0, anim1;
  logic       alive0, alive1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  queue_motion u_dut0 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable), .stomp(stomp),
    .posx(posx0), .posy(posy0), .animate_state(anim0), .alive(alive0)
  );

  queue_motion #(.X_MIN(0), .START_X(2), .SPEED(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable), .stomp(stomp),
    .posx(posx1), .posy(posy1), .animate_state(anim1), .alive(alive1)
  );

  wire [20:0] dv0 = {posx0, posy0, anim0, alive0};
  wire [20:0] dv1 = {posx1, posy1, anim1, alive1};

  // ---------------- behavioural reference model ----------------
  typedef enum int {M_IDLE, M_WL, M_WR, M_DEAD} mode_t;
  int    p_xmin [2] = '{0, 0};
  int    p_xmax [2] = '{596, 596};
  int    p_start[2] = '{300, 2};
  int    p_speed[2] = '{1, 3};
  mode_t m_mode [2];
  int    m_x    [2];
  int    m_anim [2];
  int    m_alive[2];
  int    m_walk_ticks[2];
  int    m_dead_ticks[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_x[i] = p_start[i]; m_anim[i] = 0;
      m_alive[i] = 0; m_walk_ticks[i] = 0; m_dead_ticks[i] = 0;
    end
  endtask

  // One clock edge worth of behaviour for both sprites.
  task automatic model_step(input bit t, input bit e, input bit s);
    for (int i = 0; i < 2; i++) begin
      if (m_mode[i] == M_IDLE) begin
        if (t && e) begin m_mode[i] = M_WL; m_alive[i] = 1; end
      end else if (m_mode[i] == M_DEAD) begin
        if (t) begin
          m_dead_ticks[i]++;
          if (m_dead_ticks[i] == 60) begin
            m_mode[i] = M_IDLE; m_x[i] = p_start[i]; m_anim[i] = 0; m_walk_ticks[i] = 0;
          end
        end
      end else if (s) begin
        m_mode[i] = M_DEAD; m_alive[i] = 0; m_dead_ticks[i] = 0;
      end else if (t && e) begin
        m_walk_ticks[i]++;
        if (m_walk_ticks[i] % 8 == 0) m_anim[i] = 1 - m_anim[i];
        if (m_mode[i] == M_WL) begin
          if (m_x[i] - p_speed[i] < p_xmin[i]) begin m_x[i] = p_xmin[i]; m_mode[i] = M_WR; end
          else m_x[i] = m_x[i] - p_speed[i];
        end else begin
          if (m_x[i] + p_speed[i] > p_xmax[i]) begin m_x[i] = p_xmax[i]; m_mode[i] = M_WL; end
          else m_x[i] = m_x[i] + p_speed[i];
        end
      end
    end
  endtask

  function automatic logic [20:0] exp_vec(input int i);
    return {10'(m_x[i]), 9'd380, 1'(m_anim[i]), 1'(m_alive[i])};
  endfunction

  // Drive one cycle: inputs change on the falling edge, outputs are sampled 1ns after rising.
  task automatic cyc(input bit t, input bit e, input bit s);
    @(negedge clk);
    frame_tick = t; enable = e; stomp = s;
    @(posedge clk);
    model_step(t, e, s);
    #1;
    frame_tick = 1'b0; stomp = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dv0 !== {10'd300, 9'd380, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_dut0: got %h expected %h", dv0, {10'd300, 9'd380, 1'b0, 1'b0});
    end
    checks++;
    if (dv1 !== {10'd2, 9'd380, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_dut1: got %h expected %h", dv1, {10'd2, 9'd380, 1'b0, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_start();
    cyc(1, 1, 0);
    checks++;
    if (dv0 !== {10'd300, 9'd380, 1'b0, 1'b1}) begin
      errors++; $display("FAIL start_dut0: got %h expected %h", dv0, {10'd300, 9'd380, 1'b0, 1'b1});
    end
    checks++;
    if (dv1 !== exp_vec(1)) begin
      errors++; $display("FAIL start_dut1: got %h expected %h", dv1, exp_vec(1));
    end
  endtask

  task automatic test_min_bounce();
    cyc(1, 1, 0);
    checks++;
    if (posx1 !== 10'd0) begin
      errors++; $display("FAIL min_clamp: got posx %0d expected 0", posx1);
    end
    cyc(1, 1, 0);
    checks++;
    if (posx1 !== 10'd3) begin
      errors++; $display("FAIL min_turn: got posx %0d expected 3", posx1);
    end
    checks++;
    if (dv0 !== exp_vec(0)) begin
      errors++; $display("FAIL min_bounce_dut0: got %h expected %h", dv0, exp_vec(0));
    end
  endtask

  task automatic test_anim();
    // Two walk ticks already happened; six more make eight.
    for (int k = 0; k < 6; k++) begin
      cyc(1, 1, 0);
      if (k == 4) begin
        checks++;
        if (anim0 !== 1'b0) begin
          errors++; $display("FAIL anim_tick7: got %0b expected 0", anim0);
        end
      end
    end
    checks++;
    if (dv0 !== {10'd292, 9'd380, 1'b1, 1'b1}) begin
      errors++; $display("FAIL anim_tick8: got %h expected %h", dv0, {10'd292, 9'd380, 1'b1, 1'b1});
    end
    repeat (8) cyc(1, 1, 0);
    checks++;
    if (dv0 !== {10'd284, 9'd380, 1'b0, 1'b1}) begin
      errors++; $display("FAIL anim_tick16: got %h expected %h", dv0, {10'd284, 9'd380, 1'b0, 1'b1});
    end
    checks++;
    if (dv1 !== exp_vec(1)) begin
      errors++; $display("FAIL anim_dut1: got %h expected %h", dv1, exp_vec(1));
    end
  endtask

  task automatic test_stomp();
    int guard = 0;
    while (m_x[0] != 250 && guard < 200) begin cyc(1, 1, 0); guard++; end
    checks++;
    if (posx0 !== 10'd250) begin
      errors++; $display("FAIL stomp_setup: got posx %0d expected 250", posx0);
    end
    cyc(1, 1, 1);
    checks++;
    if ({posx0, alive0} !== {10'd250, 1'b0}) begin
      errors++; $display("FAIL stomp_hit: got posx %0d alive %0b expected 250/0", posx0, alive0);
    end
    cyc(0, 1, 1);
    checks++;
    if (dv0 !== exp_vec(0)) begin
      errors++; $display("FAIL stomp_in_dead: got %h expected %h", dv0, exp_vec(0));
    end
    repeat (59) cyc(1, 1, 0);
    checks++;
    if ({posx0, alive0} !== {10'd250, 1'b0}) begin
      errors++; $display("FAIL dead_tick59: got posx %0d alive %0b expected 250/0", posx0, alive0);
    end
    cyc(1, 1, 0);
    checks++;
    if (dv0 !== {10'd300, 9'd380, 1'b0, 1'b0}) begin
      errors++; $display("FAIL respawn: got %h expected %h", dv0, {10'd300, 9'd380, 1'b0, 1'b0});
    end
    // Respawned sprite is idle: next tick arms it without moving.
    cyc(1, 1, 0);
    checks++;
    if ({posx0, alive0} !== {10'd300, 1'b1}) begin
      errors++; $display("FAIL restart: got posx %0d alive %0b expected 300/1", posx0, alive0);
    end
  endtask

  task automatic test_max_bounce();
    int guard = 0;
    while (!(m_mode[0] == M_WR && m_x[0] == 595) && guard < 2000) begin cyc(1, 1, 0); guard++; end
    checks++;
    if (posx0 !== 10'd595 || guard >= 2000) begin
      errors++; $display("FAIL max_setup: got posx %0d expected 595 (ticks %0d)", posx0, guard);
    end
    cyc(1, 1, 0);
    checks++;
    if (posx0 !== 10'd596) begin
      errors++; $display("FAIL max_reach: got posx %0d expected 596", posx0);
    end
    cyc(1, 1, 0);
    checks++;
    if (posx0 !== 10'd596) begin
      errors++; $display("FAIL max_hold: got posx %0d expected 596", posx0);
    end
    cyc(1, 1, 0);
    checks++;
    if (posx0 !== 10'd595) begin
      errors++; $display("FAIL max_turn: got posx %0d expected 595", posx0);
    end
    checks++;
    if (dv1 !== exp_vec(1)) begin
      errors++; $display("FAIL max_dut1: got %h expected %h", dv1, exp_vec(1));
    end
  endtask

  task automatic test_enable_hold();
    logic [20:0] held0, held1;
    held0 = exp_vec(0);
    held1 = exp_vec(1);
    repeat (20) cyc(1, 0, 0);
    checks++;
    if (dv0 !== held0) begin
      errors++; $display("FAIL enable_hold_dut0: got %h expected %h", dv0, held0);
    end
    checks++;
    if (dv1 !== held1) begin
      errors++; $display("FAIL enable_hold_dut1: got %h expected %h", dv1, held1);
    end
  endtask

  task automatic test_async_reset();
    repeat (5) cyc(1, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dv0 !== {10'd300, 9'd380, 1'b0, 1'b0}) begin
      errors++; $display("FAIL async_reset_dut0: got %h expected %h", dv0, {10'd300, 9'd380, 1'b0, 1'b0});
    end
    checks++;
    if (dv1 !== {10'd2, 9'd380, 1'b0, 1'b0}) begin
      errors++; $display("FAIL async_reset_dut1: got %h expected %h", dv1, {10'd2, 9'd380, 1'b0, 1'b0});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(2) == 0), ($urandom_range(9) != 0), ($urandom_range(39) == 0));
      checks++;
      if (dv0 !== exp_vec(0) || dv1 !== exp_vec(1)) begin
        errors++;
        if (bad < 10) $display("FAIL random_cycle%0d: got %h/%h expected %h/%h", k, dv0, dv1, exp_vec(0), exp_vec(1));
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_min_bounce();
    test_anim();
    test_stomp();
    test_max_bounce();
    test_enable_hold();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
